// File: rtl/regfile_cmd_master.sv
// Command-driven initiator for a small register file. Accepts WRITE, READ,
// ADD and XOR commands on a valid/ready channel. It runs one write, or a
// read followed by a write for the read-modify-write commands. It then
// returns exactly one response per accepted command.
module regfile_cmd_master #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              rf_wrEN,
  output logic              rf_rdEN,
  output logic [ADDR_W-1:0] rf_address,
  output logic [DATA_W-1:0] rf_wrData,
  input  logic [DATA_W-1:0] rf_rdData
);

  typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, RSP} state_t;
  typedef enum logic [1:0] {OP_WRITE = 2'b00, OP_READ = 2'b01,
                            OP_ADD = 2'b10, OP_XOR = 2'b11} op_t;

  localparam logic [31:0] NUM_REGS_U = 32'(NUM_REGS);

  state_t              state, state_nxt;
  op_t                 op_q, op_nxt;
  logic [ADDR_W-1:0]   addr_q, addr_nxt;
  logic [DATA_W-1:0]   data_q, data_nxt;

  logic                wr_en_nxt, rd_en_nxt;
  logic [ADDR_W-1:0]   address_nxt;
  logic [DATA_W-1:0]   wr_data_nxt;
  logic                rsp_valid_nxt, rsp_err_nxt;
  logic [DATA_W-1:0]   rsp_data_nxt;
  logic                addr_oor;

  // Only IDLE takes a new command, so at most one command is in flight.
  assign cmd_ready = (state == IDLE);
  assign addr_oor  = (32'(cmd_addr) >= NUM_REGS_U);

  // Next state plus the next value of every registered output.
  // Each output is computed one edge early so that it is high exactly
  // during the state it belongs to.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // skips an assignment would otherwise infer a latch.
    state_nxt     = state;
    op_nxt        = op_q;
    addr_nxt      = addr_q;
    data_nxt      = data_q;
    wr_en_nxt     = 1'b0;
    rd_en_nxt     = 1'b0;
    address_nxt   = rf_address;
    wr_data_nxt   = rf_wrData;
    rsp_valid_nxt = rsp_valid;
    rsp_data_nxt  = rsp_data;
    rsp_err_nxt   = rsp_err;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          op_nxt   = op_t'(cmd_op);
          addr_nxt = cmd_addr;
          data_nxt = cmd_data;
          if (addr_oor) begin
            // Bad address: answer at once and leave the register file alone.
            state_nxt     = RSP;
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b1;
            rsp_data_nxt  = '0;
          end else if (op_t'(cmd_op) == OP_WRITE) begin
            state_nxt   = WR;
            wr_en_nxt   = 1'b1;
            address_nxt = cmd_addr;
            wr_data_nxt = cmd_data;
          end else begin
            state_nxt   = RD_REQ;
            rd_en_nxt   = 1'b1;
            address_nxt = cmd_addr;
          end
        end
      end

      RD_REQ: begin
        state_nxt = RD_WAIT;
      end

      RD_WAIT: begin
        // rf_rdData is valid now and is consumed in this cycle.
        if (op_q == OP_READ) begin
          state_nxt     = RSP;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b0;
          rsp_data_nxt  = rf_rdData;
        end else begin
          state_nxt   = WR;
          wr_en_nxt   = 1'b1;
          address_nxt = addr_q;
          // The adder is DATA_W wide, so the carry out is discarded.
          wr_data_nxt = (op_q == OP_ADD) ? (rf_rdData + data_q)
                                         : (rf_rdData ^ data_q);
        end
      end

      WR: begin
        state_nxt     = RSP;
        rsp_valid_nxt = 1'b1;
        rsp_err_nxt   = 1'b0;
        rsp_data_nxt  = rf_wrData;
      end

      RSP: begin
        if (rsp_ready) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b0;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, latched command and registered outputs. Reset drops any in-flight
  // command with no response and no write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      op_q       <= OP_WRITE;
      addr_q     <= '0;
      data_q     <= '0;
      rf_wrEN    <= 1'b0;
      rf_rdEN    <= 1'b0;
      rf_address <= '0;
      rf_wrData  <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register here samples the values from before this edge.
      state      <= state_nxt;
      op_q       <= op_nxt;
      addr_q     <= addr_nxt;
      data_q     <= data_nxt;
      rf_wrEN    <= wr_en_nxt;
      rf_rdEN    <= rd_en_nxt;
      rf_address <= address_nxt;
      rf_wrData  <= wr_data_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_data   <= rsp_data_nxt;
      rsp_err    <= rsp_err_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_cmd_master.sv
// Self-checking bench for regfile_cmd_master. It emulates the attached
// 8x16 register file and keeps a plain array as the reference register
// contents. It then runs directed and randomized command streams, using
// response backpressure.
module tb_regfile_cmd_master;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = '0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              rf_wrEN, rf_rdEN;
  logic [ADDR_W-1:0] rf_address;
  logic [DATA_W-1:0] rf_wrData;
  logic [DATA_W-1:0] rf_rdData;

  // Second instance with only six registers, used for the error path.
  logic              cmd_valid6 = 1'b0;
  logic              cmd_ready6;
  logic [1:0]        cmd_op6 = '0;
  logic [ADDR_W-1:0] cmd_addr6 = '0;
  logic [DATA_W-1:0] cmd_data6 = '0;
  logic              rsp_valid6;
  logic              rsp_ready6 = 1'b0;
  logic [DATA_W-1:0] rsp_data6;
  logic              rsp_err6;
  logic              rf_wrEN6, rf_rdEN6;
  logic [ADDR_W-1:0] rf_address6;
  logic [DATA_W-1:0] rf_wrData6;
  logic [DATA_W-1:0] rf_rdData6;
  assign rf_rdData6 = 16'h1234;

  int vectors = 0;
  int miscompares = 0;
  int wr_pulses = 0;
  int act6 = 0;

  logic [DATA_W-1:0] rf_mem  [8];
  logic [DATA_W-1:0] ref_mem [8];

  always #5 clk = ~clk;

  regfile_cmd_master u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .rf_wrEN(rf_wrEN), .rf_rdEN(rf_rdEN), .rf_address(rf_address),
    .rf_wrData(rf_wrData), .rf_rdData(rf_rdData)
  );

  regfile_cmd_master #(.NUM_REGS(6)) u_dut6 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid6), .cmd_ready(cmd_ready6), .cmd_op(cmd_op6),
    .cmd_addr(cmd_addr6), .cmd_data(cmd_data6),
    .rsp_valid(rsp_valid6), .rsp_ready(rsp_ready6), .rsp_data(rsp_data6),
    .rsp_err(rsp_err6),
    .rf_wrEN(rf_wrEN6), .rf_rdEN(rf_rdEN6), .rf_address(rf_address6),
    .rf_wrData(rf_wrData6), .rf_rdData(rf_rdData6)
  );

  // Register file emulation: write on the sampling edge, read data registered.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= '0;
      rf_rdData <= '0;
    end else begin
      if (rf_wrEN) rf_mem[rf_address] <= rf_wrData;
      if (rf_rdEN) rf_rdData <= rf_mem[rf_address];
    end
  end

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Enables are exclusive and silent while idle or responding.
  always @(negedge clk) begin
    if (rst) begin
      check("rf_excl", 32'(rf_wrEN & rf_rdEN), 32'd0);
      if (cmd_ready || rsp_valid) check("rf_quiet", 32'({rf_wrEN, rf_rdEN}), 32'd0);
      if (rf_wrEN) wr_pulses <= wr_pulses + 1;
      if (rf_wrEN6 || rf_rdEN6) act6 <= act6 + 1;
    end
  end

  // One command, start to finish, checked against the reference array.
  task automatic do_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data, input int hold);
    logic [DATA_W-1:0] exp_data;
    int exp_lat, exp_wr, exp_rd, lat, nwr, nrd, guard;
    case (op)
      OP_WR:   begin exp_data = data;                 exp_lat = 2; end
      OP_RD:   begin exp_data = ref_mem[addr];        exp_lat = 3; end
      OP_ADD:  begin exp_data = ref_mem[addr] + data; exp_lat = 4; end
      default: begin exp_data = ref_mem[addr] ^ data; exp_lat = 4; end
    endcase
    exp_wr = (op == OP_RD) ? 0 : 1;
    exp_rd = (op == OP_WR) ? 0 : 1;
    if (op != OP_RD) ref_mem[addr] = exp_data;

    @(negedge clk);
    guard = 0;
    while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) check("ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
    rsp_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_addr = 3'($urandom);
    cmd_data = 16'($urandom);

    lat = 1; nwr = 0; nrd = 0;
    while (!rsp_valid && lat < 20) begin
      if (rf_wrEN) begin
        nwr++;
        check("wr_addr", 32'(rf_address), 32'(addr));
        check("wr_data", 32'(rf_wrData), 32'(exp_data));
      end
      if (rf_rdEN) begin
        nrd++;
        check("rd_addr", 32'(rf_address), 32'(addr));
      end
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("wr_count", 32'(nwr), 32'(exp_wr));
    check("rd_count", 32'(nrd), 32'(exp_rd));
    check("rsp_data", 32'(rsp_data), 32'(exp_data));
    check("rsp_err", 32'(rsp_err), 32'd0);
    check("busy_ready", 32'(cmd_ready), 32'd0);

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", 32'(rsp_data), 32'(exp_data));
      check("hold_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_done", 32'(rsp_valid), 32'd0);
    check("ready_back", 32'(cmd_ready), 32'd1);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int act_before, wr_before;
    logic [ADDR_W-1:0] bad_addr [2];
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;

    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_wren", 32'(rf_wrEN), 32'd0);
    check("rst_rden", 32'(rf_rdEN), 32'd0);
    check("rst_address", 32'(rf_address), 32'd0);
    check("rst_wrdata", 32'(rf_wrData), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_cmd_ready6", 32'(cmd_ready6), 32'd1);
    rst = 1'b1;

    // Basic write/read.
    do_cmd(OP_WR, 3'd0, 16'd5, 0);
    do_cmd(OP_RD, 3'd0, 16'd0, 0);
    do_cmd(OP_WR, 3'd1, 16'd13, 0);
    do_cmd(OP_WR, 3'd5, 16'd25, 0);
    do_cmd(OP_WR, 3'd7, 16'd9, 0);
    check("addr_hold", 32'(rf_address), 32'd7);
    check("wrdata_hold", 32'(rf_wrData), 32'd9);
    do_cmd(OP_RD, 3'd1, 16'd0, 0);
    do_cmd(OP_RD, 3'd5, 16'd0, 0);
    do_cmd(OP_RD, 3'd7, 16'd0, 0);

    // Read-modify-write with wrap.
    do_cmd(OP_WR, 3'd2, 16'hFFFF, 0);
    do_cmd(OP_ADD, 3'd2, 16'd3, 0);
    check("add_wrap", 32'(ref_mem[2]), 32'h0002);
    do_cmd(OP_XOR, 3'd2, 16'h00F0, 0);
    do_cmd(OP_RD, 3'd2, 16'd0, 0);

    // Response backpressure.
    do_cmd(OP_RD, 3'd5, 16'd0, 5);

    // Out-of-range addresses on the six-register instance.
    bad_addr[0] = 3'd7;
    bad_addr[1] = 3'd6;
    @(negedge clk);
    act_before = act6;
    for (int k = 0; k < 2; k++) begin
      cmd_valid6 = 1'b1; cmd_op6 = (k == 0) ? OP_RD : OP_WR;
      cmd_addr6 = bad_addr[k]; cmd_data6 = 16'hBEEF; rsp_ready6 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid6 = 1'b0;
      check("err_valid", 32'(rsp_valid6), 32'd1);
      check("err_flag", 32'(rsp_err6), 32'd1);
      check("err_data", 32'(rsp_data6), 32'd0);
      @(negedge clk);
      check("err_done", 32'(rsp_valid6), 32'd0);
      check("err_ready_back", 32'(cmd_ready6), 32'd1);
    end
    #1;
    check("err_no_rf_activity", 32'(act6), 32'(act_before));
    // An in-range read on the same instance still works.
    cmd_valid6 = 1'b1; cmd_op6 = OP_RD; cmd_addr6 = 3'd3;
    @(posedge clk);
    @(negedge clk);
    cmd_valid6 = 1'b0;
    check("ok6_rden", 32'(rf_rdEN6), 32'd1);
    check("ok6_wait1", 32'(rsp_valid6), 32'd0);
    @(negedge clk);
    check("ok6_wait2", 32'(rsp_valid6), 32'd0);
    @(negedge clk);
    check("ok6_valid", 32'(rsp_valid6), 32'd1);
    check("ok6_err", 32'(rsp_err6), 32'd0);
    check("ok6_data", 32'(rsp_data6), 32'h1234);
    @(negedge clk);
    rsp_ready6 = 1'b0;

    // Reset during RD_WAIT of an ADD.
    do_cmd(OP_WR, 3'd4, 16'h0ABC, 0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_addr = 3'd4; cmd_data = 16'h0101;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid_rden", 32'(rf_rdEN), 32'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rsp_data", 32'(rsp_data), 32'd0);
    check("mid_rsp_err", 32'(rsp_err), 32'd0);
    check("mid_wren", 32'(rf_wrEN), 32'd0);
    check("mid_rden0", 32'(rf_rdEN), 32'd0);
    check("mid_address", 32'(rf_address), 32'd0);
    check("mid_wrdata", 32'(rf_wrData), 32'd0);
    check("mid_cmd_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    rsp_ready = 1'b0;
    wr_before = wr_pulses;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("mid_no_write", 32'(wr_pulses), 32'(wr_before));
    do_cmd(OP_RD, 3'd4, 16'd0, 0);

    // Randomized stream against the reference array.
    for (int n = 0; n < 200; n++) begin
      int hold;
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      do_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
             16'($urandom), hold);
    end
    for (int a = 0; a < 8; a++) do_cmd(OP_RD, 3'(a), 16'd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
